xram_arbiter: RTL and testbench



---
 rtl/xram_arb_pkg.sv | 15 +
 rtl/xram_arbiter_if.sv | 43 ++++
 rtl/xram_arb_wdog.sv | 32 +++
 rtl/xram_arbiter.sv | 112 +++++++++++
 tb/tb_xram_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xram_arb_pkg.sv
// Shared types and constants for the two-master XRAM arbiter.
package xram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGntCpu = 2'd1,
    StGntAes = 2'd2
  } arb_state_e;

  localparam logic [15:0] XramMmioLo   = 16'hff00;
  localparam logic [15:0] XramMmioHi   = 16'hff30;
  localparam logic [7:0]  TimeoutRdata = 8'hff;
  localparam int unsigned WdogWidth    = 8;

endpackage

// File: rtl/xram_arbiter_if.sv
// CPU, AES and XRAM slave byte buses around the arbiter.
interface xram_arbiter_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wr;
  logic        cpu_stb;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;

  logic [15:0] aes_addr;
  logic [7:0]  aes_wdata;
  logic        aes_wr;
  logic        aes_stb;
  logic [7:0]  aes_rdata;
  logic        aes_ack;

  logic [15:0] s_addr;
  logic [7:0]  s_wdata;
  logic        s_wr;
  logic        s_stb;
  logic [7:0]  s_rdata;
  logic        s_ack;

  // Arbiter side: serves the two masters, drives the XRAM slave.
  modport slave (
    input  cpu_addr, cpu_wdata, cpu_wr, cpu_stb,
    output cpu_rdata, cpu_ack,
    input  aes_addr, aes_wdata, aes_wr, aes_stb,
    output aes_rdata, aes_ack,
    output s_addr, s_wdata, s_wr, s_stb,
    input  s_rdata, s_ack
  );

  // Environment side: the two masters plus the XRAM slave.
  modport master (
    output cpu_addr, cpu_wdata, cpu_wr, cpu_stb,
    input  cpu_rdata, cpu_ack,
    output aes_addr, aes_wdata, aes_wr, aes_stb,
    input  aes_rdata, aes_ack,
    input  s_addr, s_wdata, s_wr, s_stb,
    output s_rdata, s_ack
  );
endinterface

// File: rtl/xram_arb_wdog.sv
// Per-access wait counter; expired flags TIMEOUT granted cycles without an ack.
module xram_arb_wdog
  import xram_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  if (TIMEOUT == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    localparam logic [WdogWidth-1:0] Limit = WdogWidth'(TIMEOUT);
    logic [WdogWidth-1:0] r_cnt;

    // Saturates at the limit so expired stays high until the grant ends.
    always_ff @(posedge clk) begin
      if (rst || clr) begin
        r_cnt <= '0;
      end else if (en && (r_cnt != Limit)) begin
        r_cnt <= r_cnt + WdogWidth'(1);
      end
    end

    assign expired = (r_cnt == Limit);
  end

endmodule

// File: rtl/xram_arbiter.sv
// Two-master (CPU/AES) arbiter for the shared 8-bit XRAM port with access watchdog.
// Define XRAM_ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
module xram_arbiter
  import xram_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [15:0] MMIO_LO = XramMmioLo,
  parameter logic [15:0] MMIO_HI = XramMmioHi
) (
  input  logic          clk,
  input  logic          rst,
  xram_arbiter_if.slave bus,
  output logic          o_err
);

  arb_state_e r_state, w_state_d;
  logic       r_err;
  logic       w_cpu_req, w_aes_req, w_aes_wins;
  logic       w_granted, w_sel_aes, w_m_stb, w_m_ack;
  logic       w_expired, w_timeout;
  logic [7:0] w_m_rdata;

  assign w_cpu_req = bus.cpu_stb && !(bus.cpu_addr >= MMIO_LO && bus.cpu_addr < MMIO_HI);
  assign w_aes_req = bus.aes_stb;
  assign w_granted = (r_state != StIdle);
  assign w_sel_aes = (r_state == StGntAes);
  assign w_m_stb   = w_sel_aes ? bus.aes_stb : bus.cpu_stb;
  // A slave ack in the expiry cycle wins over the timeout.
  assign w_timeout = w_granted && w_expired && !bus.s_ack;
  assign w_m_ack   = bus.s_ack || w_timeout;
  assign w_m_rdata = w_timeout ? TimeoutRdata : bus.s_rdata;

  xram_arb_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (!w_granted),
    .en     (w_granted && !bus.s_ack),
    .expired(w_expired)
  );

`ifdef XRAM_ARB_RR_EN
  logic r_ptr;  // 1: AES wins the next simultaneous request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (w_granted && w_m_ack) begin
      r_ptr <= ~r_ptr;
    end
  end
  assign w_aes_wins = r_ptr;
`else
  assign w_aes_wins = 1'b0;
`endif

  always_comb begin
    w_state_d     = r_state;
    bus.s_addr    = '0;
    bus.s_wdata   = '0;
    bus.s_wr      = 1'b0;
    bus.s_stb     = 1'b0;
    bus.cpu_ack   = 1'b0;
    bus.cpu_rdata = '0;
    bus.aes_ack   = 1'b0;
    bus.aes_rdata = '0;
    // Outputs are held quiet while reset is asserted so an aborted grant never acks.
    if (!rst) begin
      unique case (r_state)
        StIdle: begin
          if (w_cpu_req && !(w_aes_req && w_aes_wins)) begin
            w_state_d = StGntCpu;
          end else if (w_aes_req) begin
            w_state_d = StGntAes;
          end
        end
        StGntCpu, StGntAes: begin
          bus.s_addr  = w_sel_aes ? bus.aes_addr  : bus.cpu_addr;
          bus.s_wdata = w_sel_aes ? bus.aes_wdata : bus.cpu_wdata;
          bus.s_wr    = w_sel_aes ? bus.aes_wr    : bus.cpu_wr;
          bus.s_stb   = w_m_stb && !w_expired;
          if (w_sel_aes) begin
            bus.aes_ack   = w_m_ack;
            bus.aes_rdata = w_m_rdata;
          end else begin
            bus.cpu_ack   = w_m_ack;
            bus.cpu_rdata = w_m_rdata;
          end
          if (bus.s_ack || !w_m_stb || w_expired) begin
            w_state_d = StIdle;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_err = r_err;

endmodule

// File: tb/tb_xram_arbiter.sv
// Scoreboard bench for xram_arbiter: per-master expected-response queues, memory reference model.
module tb_xram_arbiter;

  logic clk;
  logic rst;
  logic err;

  xram_arbiter_if bus ();

  xram_arbiter #(
    .TIMEOUT(8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .o_err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- XRAM slave model ----------------
  logic [7:0] mem [1024];
  int slv_wait;
  int slv_lat;
  bit slv_rand;
  int rand_lat;
  int lat_eff;

  always_comb begin
    lat_eff     = slv_rand ? rand_lat : slv_lat;
    bus.s_ack   = (lat_eff >= 0) && (slv_wait >= lat_eff) && (bus.s_stb || slv_wait > 0);
    bus.s_rdata = mem[bus.s_addr[9:0]];
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i) ^ 8'h3c;
      slv_wait <= 0;
    end else begin
      if (bus.s_stb && bus.s_ack && bus.s_wr) mem[bus.s_addr[9:0]] <= bus.s_wdata;
      slv_wait <= (bus.s_stb && !bus.s_ack) ? slv_wait + 1 : 0;
    end
    rand_lat <= $urandom_range(0, 3);
  end

  // ---------------- reference model and scoreboard ----------------
  logic [7:0]  ref_mem [1024];
  logic [7:0]  cpu_q [$];
  logic [7:0]  aes_q [$];
  logic [17:0] log_q [$];  // {aes, wr, addr} of each slave-completed access
  int          aes_ack_cnt;

  always @(negedge clk) begin
    logic [7:0] e;
    if (bus.cpu_ack) begin
      check("cpu_ack_expected", 32'(cpu_q.size() != 0), 1);
      check("aes_quiet", {bus.aes_ack, bus.aes_rdata}, 0);
      if (cpu_q.size() != 0) begin
        e = cpu_q.pop_front();
        check("cpu_rdata", bus.cpu_rdata, e);
      end
    end
    if (bus.aes_ack) begin
      aes_ack_cnt++;
      check("aes_ack_expected", 32'(aes_q.size() != 0), 1);
      check("cpu_quiet", {bus.cpu_ack, bus.cpu_rdata}, 0);
      if (aes_q.size() != 0) begin
        e = aes_q.pop_front();
        check("aes_rdata", bus.aes_rdata, e);
      end
    end
    if (bus.s_stb && bus.s_ack) log_q.push_back({bus.aes_ack, bus.s_wr, bus.s_addr});
  end

  // One byte access by a master: push expected response, hold stb until ack.
  task automatic access(input bit aes, input logic [15:0] addr, input bit wr,
                        input logic [7:0] wdata, input bit hold, input bit to_exp,
                        output int cyc, output bit stb_at_ack);
    logic [7:0] exp;
    bit got;
    if (to_exp) exp = 8'hff;
    else begin
      exp = ref_mem[addr[9:0]];
      if (wr) ref_mem[addr[9:0]] = wdata;
    end
    if (aes) begin
      aes_q.push_back(exp);
      bus.aes_addr = addr; bus.aes_wr = wr; bus.aes_wdata = wdata; bus.aes_stb = 1'b1;
    end else begin
      cpu_q.push_back(exp);
      bus.cpu_addr = addr; bus.cpu_wr = wr; bus.cpu_wdata = wdata; bus.cpu_stb = 1'b1;
    end
    cyc = 0;
    got = 1'b0;
    stb_at_ack = 1'b0;
    while (!got && cyc < 64) begin
      @(negedge clk);
      cyc++;
      got = aes ? bus.aes_ack : bus.cpu_ack;
      stb_at_ack = bus.s_stb;
    end
    if (!got) check(aes ? "aes_ack_arrives" : "cpu_ack_arrives", 0, 1);
    @(posedge clk);
    #1;
    if (!hold) begin
      if (aes) bus.aes_stb = 1'b0;
      else bus.cpu_stb = 1'b0;
    end
  endtask

  task automatic mmio_probe(input logic [15:0] addr, input int cycles);
    bit seen_stb;
    bit seen_ack;
    seen_stb = 1'b0;
    seen_ack = 1'b0;
    bus.cpu_addr = addr; bus.cpu_wr = 1'b0; bus.cpu_stb = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      seen_stb |= bus.s_stb;
      seen_ack |= bus.cpu_ack;
    end
    @(posedge clk);
    #1 bus.cpu_stb = 1'b0;
    check("mmio_no_stb", 32'(seen_stb), 0);
    check("mmio_no_ack", 32'(seen_ack), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    bit sa;
    int good;
    int bad;
    logic [7:0] order;
    logic [7:0] exp_order;

    rst = 1'b1;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_wr = 1'b0; bus.cpu_stb = 1'b0;
    bus.aes_addr = '0; bus.aes_wdata = '0; bus.aes_wr = 1'b0; bus.aes_stb = 1'b0;
    slv_lat = 0;
    slv_rand = 1'b0;
    aes_ack_cnt = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i) ^ 8'h3c;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_bus", {bus.s_stb, bus.s_wr, bus.s_addr, bus.s_wdata}, 0);
    check("rst_acks_err", {bus.cpu_ack, bus.aes_ack, err}, 0);
    check("rst_rdata", {bus.cpu_rdata, bus.aes_rdata}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_quiet", {bus.s_stb, bus.s_addr, bus.cpu_ack, bus.aes_ack}, 0);

    // Simultaneous CPU/AES requests held for 4 bytes each.
    log_q.delete();
    fork
      begin
        int c; bit s;
        for (int i = 0; i < 4; i++) access(0, 16'h0110 + 16'(i), 0, 0, i < 3, 0, c, s);
      end
      begin
        int c; bit s;
        for (int i = 0; i < 4; i++) access(1, 16'h0210 + 16'(i), 0, 0, i < 3, 0, c, s);
      end
    join
    check("arb_count", log_q.size(), 8);
    order = '0;
    for (int i = 0; i < 8 && i < log_q.size(); i++) order[i] = log_q[i][17];
`ifdef XRAM_ARB_RR_EN
    exp_order = 8'b1010_1010;
`else
    exp_order = 8'b1111_0000;
`endif
    check("arb_order", order, exp_order);

    // Single CPU read of 0x0100 with a zero-wait slave.
    @(posedge clk); #1;
    log_q.delete();
    access(0, 16'h0100, 0, 0, 1, 0, cyc, sa);
    check("rd_ack_cycle", cyc, 2);
    @(negedge clk);
    check("rd_back_idle", {bus.s_stb, bus.cpu_ack}, 0);
    bus.cpu_stb = 1'b0;
    check("rd_slave_access", log_q.size() == 1 ? 32'(log_q[0]) : 32'hdead, {2'b00, 16'h0100});

    // MMIO window: strobes inside are dropped, the bounds just outside are forwarded.
    @(posedge clk); #1;
    mmio_probe(16'hff20, 20);
    mmio_probe(16'hff00, 5);
    mmio_probe(16'hff2f, 5);
    access(0, 16'hfeff, 0, 0, 0, 0, cyc, sa);
    check("mmio_below_fwd", cyc, 2);
    access(0, 16'hff30, 0, 0, 0, 0, cyc, sa);
    check("mmio_above_fwd", cyc, 2);

    // AES 16-byte write burst, 2-cycle slave latency.
    slv_lat = 2;
    log_q.delete();
    aes_ack_cnt = 0;
    for (int i = 0; i < 16; i++)
      access(1, 16'h0200 + 16'(i), 1, 8'($urandom_range(0, 255)), i < 15, 0, cyc, sa);
    repeat (2) @(negedge clk);
    check("burst_acks", aes_ack_cnt, 16);
    check("burst_len", log_q.size(), 16);
    good = 0;
    for (int i = 0; i < 16 && i < log_q.size(); i++)
      if (log_q[i] == {1'b1, 1'b1, 16'h0200 + 16'(i)}) good++;
    check("burst_seq", good, 16);

    // Randomized concurrent traffic on disjoint address regions.
    slv_rand = 1'b1;
    fork
      begin
        int c; bit s; bit h;
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 7) == 0) begin
            bus.cpu_addr = 16'hff00 + 16'($urandom_range(0, 47));
            bus.cpu_wr = 1'b0;
            bus.cpu_stb = 1'b1;
            repeat (3) @(negedge clk);
            @(posedge clk);
            #1 bus.cpu_stb = 1'b0;
          end else begin
            h = (i != 39) && ($urandom_range(0, 1) == 1);
            access(0, 16'h0100 + 16'($urandom_range(0, 63)), $urandom_range(0, 1) == 1,
                   8'($urandom_range(0, 255)), h, 0, c, s);
            if (!h) repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
          end
        end
        bus.cpu_stb = 1'b0;
      end
      begin
        int c; bit s; bit h;
        for (int i = 0; i < 40; i++) begin
          h = (i != 39) && ($urandom_range(0, 1) == 1);
          access(1, 16'h0200 + 16'($urandom_range(0, 63)), $urandom_range(0, 1) == 1,
                 8'($urandom_range(0, 255)), h, 0, c, s);
          if (!h) repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        bus.aes_stb = 1'b0;
      end
    join
    slv_rand = 1'b0;
    repeat (4) @(negedge clk);
    bad = 0;
    for (int i = 16'h0100; i < 16'h0300; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_image", bad, 0);
    check("cpu_q_drained", cpu_q.size(), 0);
    check("aes_q_drained", aes_q.size(), 0);

    // Slave ack lands on the watchdog expiry cycle: real data, no error.
    @(posedge clk); #1;
    slv_lat = 8;
    access(1, 16'h0220, 0, 0, 0, 0, cyc, sa);
    check("race_ack_cycle", cyc, 10);
    check("race_no_err", 32'(err), 0);

    // Slave never acks: timeout ack with 8'hff on the 9th granted cycle.
    slv_lat = -1;
    access(1, 16'h0221, 0, 0, 1, 1, cyc, sa);
    check("to_ack_cycle", cyc, 10);
    check("to_no_s_stb", 32'(sa), 0);
    check("to_err_set", 32'(err), 1);
    @(negedge clk);
    check("to_back_idle", {bus.s_stb, bus.aes_ack}, 0);
    bus.aes_stb = 1'b0;

    // Reset pulsed in the middle of a grant.
    @(posedge clk); #1;
    bus.cpu_addr = 16'h0105; bus.cpu_wr = 1'b1; bus.cpu_wdata = 8'haa; bus.cpu_stb = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pre_grant", 32'(bus.s_stb), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_s_bus", {bus.s_stb, bus.s_wr, bus.s_addr, bus.s_wdata}, 0);
    check("rst_mid_acks", {bus.cpu_ack, bus.aes_ack, bus.cpu_rdata, bus.aes_rdata}, 0);
    check("rst_mid_err", 32'(err), 0);
    bus.cpu_stb = 1'b0;
    bus.cpu_wr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_no_stale_ack", cpu_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
